// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings,
// legal lane masks, the captured-request payload and lane helpers.
package dmem_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned CNT_W  = 4;

    // FSM state encoding
    localparam logic [1:0] DMEM_IDLE = 2'd0;
    localparam logic [1:0] DMEM_WAIT = 2'd1;
    localparam logic [1:0] DMEM_RESP = 2'd2;

    // Legal lane masks: single bytes, aligned halfwords, full word
    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b1100;
    localparam logic [3:0] MASK_W  = 4'b1111;

    // Request attributes latched at accept (word index kept separately
    // because its width follows the ADDR_W parameter).
    typedef struct packed {
        logic              rd;
        logic              wr;
        logic              err;
        logic [LANES-1:0]  mask;
        logic [DATA_W-1:0] data;
    } dmem_req_t;

    // True when the mask is one of the supported access shapes.
    function automatic logic mask_legal(input logic [3:0] m);
        return (m == MASK_B0) || (m == MASK_B1) || (m == MASK_B2) ||
               (m == MASK_B3) || (m == MASK_H0) || (m == MASK_H1) ||
               (m == MASK_W);
    endfunction

    // Right-align the lanes selected by the mask, zero-extended.
    // Any other mask (including all-zero) yields 0.
    function automatic logic [31:0] lane_extract(input logic [3:0]  m,
                                                 input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        case (m)
            MASK_B0: r = {24'h0, w[7:0]};
            MASK_B1: r = {24'h0, w[15:8]};
            MASK_B2: r = {24'h0, w[23:16]};
            MASK_B3: r = {24'h0, w[31:24]};
            MASK_H0: r = {16'h0, w[15:0]};
            MASK_H1: r = {16'h0, w[31:16]};
            MASK_W:  r = w;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_bank_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a
// registered, enabled read port. The array has no reset.
//   clk   : clock
//   waddr : write word index      wdata : lane-positioned write data
//   we    : byte write enables    re    : read enable
//   raddr : read word index       q     : registered read data (held when re=0)
module dmem_bank_ram
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        we,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       q
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    // Byte-lane writes and registered read
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: terminates the execute stage's memory request
// interface, holds the data RAM, stalls the pipeline via busy for each
// access and returns right-aligned load data or an error indication.
//   clk, rst        : clock, asynchronous active-high reset
//   memAddr         : byte address (word index = memAddr[ADDR_W+1:2])
//   memData         : lane-positioned store data
//   readWr, writeWr : load / store request
//   rmask, wmask    : load / store lane masks
//   rdata           : last load result, right-aligned, zero-extended
//   rvalid, wdone   : one-cycle load / store response pulses
//   busy            : stall request (combinational)
//   err             : one-cycle pulse with the response of a rejected request
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] memAddr,
    input  logic [31:0] memData,
    input  logic        readWr,
    input  logic        writeWr,
    input  logic [3:0]  rmask,
    input  logic [3:0]  wmask,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        wdone,
    output logic        busy,
    output logic        err
);

    logic              req;
    logic [3:0]        act_mask;
    logic              out_of_range;
    dmem_req_t         in_req;
    logic [ADDR_W-1:0] in_idx;

    logic [1:0]        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    dmem_req_t         cap;
    logic [ADDR_W-1:0] cap_idx;
    logic              capture;
    logic              enter_resp;

    dmem_req_t         eff;
    logic [ADDR_W-1:0] eff_idx;

    logic              rvalid_d, wdone_d, err_d;
    logic [3:0]        out_mask, out_mask_d;

    logic [3:0]        ram_we;
    logic              ram_re;
    logic [31:0]       ram_q;

    // Incoming request decode, including error classification
    assign req          = readWr | writeWr;
    assign act_mask     = readWr ? rmask : wmask;
    assign out_of_range = (memAddr >> (ADDR_W + 2)) != 32'd0;
    assign in_idx       = memAddr[ADDR_W+1:2];

    always_comb begin
        in_req      = '0;
        in_req.rd   = readWr;
        in_req.wr   = writeWr;
        in_req.err  = (readWr & writeWr) | ~mask_legal(act_mask) | out_of_range;
        in_req.mask = act_mask;
        in_req.data = memData;
    end

    // With LATENCY==1 the response is entered straight from IDLE, so the
    // live request is used; otherwise the captured copy is.
    assign eff     = (state == DMEM_IDLE) ? in_req : cap;
    assign eff_idx = (state == DMEM_IDLE) ? in_idx : cap_idx;

    assign busy = ((state == DMEM_IDLE) & req) | (state == DMEM_WAIT);

    // Next state, counter and registered-output values
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        capture    = 1'b0;
        enter_resp = 1'b0;
        rvalid_d   = 1'b0;
        wdone_d    = 1'b0;
        err_d      = 1'b0;
        out_mask_d = out_mask;

        case (state)
            DMEM_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_d    = DMEM_RESP;
                        cnt_d      = '0;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = DMEM_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            DMEM_WAIT: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_d    = DMEM_RESP;
                    enter_resp = 1'b1;
                end
            end
            DMEM_RESP: begin
                // Never re-accept here: upstream still presents the old request.
                state_d = DMEM_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = DMEM_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (enter_resp) begin
            rvalid_d = eff.rd;
            wdone_d  = eff.wr;
            err_d    = eff.err;
            // A zero mask makes rdata read as 0 for a rejected load.
            if (eff.rd) begin
                out_mask_d = eff.err ? 4'b0000 : eff.mask;
            end
        end
    end

    // State, capture and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DMEM_IDLE;
            cnt      <= '0;
            cap      <= '0;
            cap_idx  <= '0;
            rvalid   <= 1'b0;
            wdone    <= 1'b0;
            err      <= 1'b0;
            out_mask <= 4'b0000;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            rvalid   <= rvalid_d;
            wdone    <= wdone_d;
            err      <= err_d;
            out_mask <= out_mask_d;
            if (capture) begin
                cap     <= in_req;
                cap_idx <= in_idx;
            end
        end
    end

    // RAM strobes; rst gating keeps a commit edge that coincides with
    // reset assertion from writing.
    assign ram_we = (enter_resp & eff.wr & ~eff.err & ~rst) ? eff.mask : 4'b0000;
    assign ram_re = enter_resp & eff.rd & ~eff.err;

    dmem_bank_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .waddr (eff_idx),
        .wdata (eff.data),
        .we    (ram_we),
        .re    (ram_re),
        .raddr (eff_idx),
        .q     (ram_q)
    );

    // RAM read register and out_mask only change on a load response,
    // so rdata holds until the next one.
    assign rdata = lane_extract(out_mask, ram_q);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table at LATENCY=2, reset
// abort, back-to-back loads, and a latency sweep on extra instances.
module tb_dmem_responder;

    localparam int unsigned ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] memAddr, memData;
    logic        readWr, writeWr;
    logic [3:0]  rmask, wmask;
    logic [31:0] rdata;
    logic        rvalid, wdone, busy, err;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .memAddr(memAddr), .memData(memData),
        .readWr(readWr), .writeWr(writeWr), .rmask(rmask), .wmask(wmask),
        .rdata(rdata), .rvalid(rvalid), .wdone(wdone), .busy(busy), .err(err)
    );

    // Latency sweep instances (index 0:1, 1:3, 2:15)
    logic [2:0]  sw_read, sw_rvalid, sw_wdone, sw_busy, sw_err;
    logic [31:0] sw_rdata [3];
    logic [31:0] sw_addr, sw_data;
    logic [3:0]  sw_mask;

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .memAddr(sw_addr), .memData(sw_data),
        .readWr(sw_read[0]), .writeWr(1'b0), .rmask(sw_mask), .wmask(sw_mask),
        .rdata(sw_rdata[0]), .rvalid(sw_rvalid[0]), .wdone(sw_wdone[0]),
        .busy(sw_busy[0]), .err(sw_err[0])
    );
    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .memAddr(sw_addr), .memData(sw_data),
        .readWr(sw_read[1]), .writeWr(1'b0), .rmask(sw_mask), .wmask(sw_mask),
        .rdata(sw_rdata[1]), .rvalid(sw_rvalid[1]), .wdone(sw_wdone[1]),
        .busy(sw_busy[1]), .err(sw_err[1])
    );
    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(15)) u_l15 (
        .clk(clk), .rst(rst), .memAddr(sw_addr), .memData(sw_data),
        .readWr(sw_read[2]), .writeWr(1'b0), .rmask(sw_mask), .wmask(sw_mask),
        .rdata(sw_rdata[2]), .rvalid(sw_rvalid[2]), .wdone(sw_wdone[2]),
        .busy(sw_busy[2]), .err(sw_err[2])
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic        xrv;
        logic        xwd;
        logic        xerr;
        logic [31:0] xrdata;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] rm, input logic [3:0] wm,
                                input logic xrv, input logic xwd, input logic xerr,
                                input logic [31:0] xd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.data = d; v.rm = rm; v.wm = wm;
        v.xrv = xrv; v.xwd = xwd; v.xerr = xerr; v.xrdata = xd;
        return v;
    endfunction

    localparam int NV = 21;
    vec_t vt [NV];

    // One request, entered #1 after a rising edge with the DUT idle.
    // Returns cycles from accept edge to response, busy cycles before the
    // response, and the response-cycle outputs. Ends #1 after the exit edge.
    task automatic xact(input vec_t v, output int lat, output int nbusy,
                        output logic rv, output logic wd, output logic er,
                        output logic rb, output logic [31:0] rd_o);
        readWr = v.rd; writeWr = v.wr; memAddr = v.addr; memData = v.data;
        rmask = v.rm; wmask = v.wm;
        lat = 0; nbusy = 0; rv = 1'b0; wd = 1'b0; er = 1'b0; rb = 1'b1; rd_o = '0;
        @(negedge clk);
        if (busy) nbusy++;
        @(posedge clk);
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (rvalid || wdone) begin
                rv = rvalid; wd = wdone; er = err; rb = busy; rd_o = rdata;
                break;
            end
            if (busy) nbusy++;
        end
        @(posedge clk);
        #1;
        readWr = 1'b0; writeWr = 1'b0;
    endtask

    // Latency sweep on one extra instance, request held through the exit edge.
    task automatic sweep(input int k, input int lat_exp);
        int c;
        int extra;
        sw_read = '0;
        sw_read[k] = 1'b1;
        @(negedge clk);
        check($sformatf("sweep%0d.accept_busy", lat_exp), 32'(sw_busy[k]), 32'd1);
        @(posedge clk);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!sw_rvalid[k] && c < 40);
        check($sformatf("sweep%0d.latency", lat_exp), 32'(c), 32'(lat_exp));
        check($sformatf("sweep%0d.resp_busy", lat_exp), 32'(sw_busy[k]), 32'd0);
        check($sformatf("sweep%0d.resp_err_wdone", lat_exp), {30'd0, sw_err[k], sw_wdone[k]}, 32'd0);
        @(posedge clk);
        #1;
        sw_read = '0;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (sw_rvalid[k]) extra++;
        end
        check($sformatf("sweep%0d.no_reaccept", lat_exp), 32'(extra), 32'd0);
    endtask

    initial begin
        int          lat, nbusy, cyc, pulses, last_pulse, guard;
        logic        rv, wd, er, rb;
        logic [31:0] rd_o, last_rdata;
        logic [31:0] ba [4];
        logic [3:0]  bm [4];
        logic [31:0] bx [4];

        rst = 1'b1; readWr = 1'b0; writeWr = 1'b0; memAddr = '0; memData = '0;
        rmask = '0; wmask = '0;
        sw_read = '0; sw_addr = '0; sw_data = '0; sw_mask = 4'b1111;

        //            rd    wr    addr          data          rm       wm       rv    wd    err   rdata
        vt[0]  = mk(1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 32'h0);
        vt[1]  = mk(1'b1, 1'b0, 32'h10,   32'h0,        4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        vt[2]  = mk(1'b0, 1'b1, 32'h10,   32'h00AB0000, 4'b0000, 4'b0100, 1'b0, 1'b1, 1'b0, 32'h0);
        vt[3]  = mk(1'b1, 1'b0, 32'h10,   32'h0,        4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h000000AB);
        vt[4]  = mk(1'b1, 1'b0, 32'h10,   32'h0,        4'b1100, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0000DEAB);
        vt[5]  = mk(1'b1, 1'b0, 32'h10,   32'h0,        4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h000000EF);
        vt[6]  = mk(1'b1, 1'b0, 32'h10,   32'h0,        4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0000BEEF);
        vt[7]  = mk(1'b1, 1'b0, 32'h10,   32'h0,        4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h000000BE);
        vt[8]  = mk(1'b1, 1'b0, 32'h10,   32'h0,        4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h000000DE);
        vt[9]  = mk(1'b1, 1'b0, 32'h13,   32'h0,        4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h000000EF);
        vt[10] = mk(1'b1, 1'b0, 32'h10,   32'h0,        4'b0101, 4'b0000, 1'b1, 1'b0, 1'b1, 32'h0);
        vt[11] = mk(1'b1, 1'b0, 32'h10,   32'h0,        4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 32'hDEABBEEF);
        vt[12] = mk(1'b0, 1'b1, 32'h10,   32'h12345678, 4'b0000, 4'b0110, 1'b0, 1'b1, 1'b1, 32'h0);
        vt[13] = mk(1'b1, 1'b0, 32'h10,   32'h0,        4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 32'hDEABBEEF);
        vt[14] = mk(1'b1, 1'b1, 32'h10,   32'h0,        4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, 32'h0);
        vt[15] = mk(1'b1, 1'b0, 32'h10,   32'h0,        4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 32'hDEABBEEF);
        vt[16] = mk(1'b0, 1'b1, 32'h1010, 32'h0,        4'b0000, 4'b1111, 1'b0, 1'b1, 1'b1, 32'h0);
        vt[17] = mk(1'b1, 1'b0, 32'h10,   32'h0,        4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 32'hDEABBEEF);
        vt[18] = mk(1'b1, 1'b0, 32'h1000, 32'h0,        4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 32'h0);
        vt[19] = mk(1'b0, 1'b1, 32'h20,   32'h11111111, 4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 32'h0);
        vt[20] = mk(1'b1, 1'b0, 32'h20,   32'h0,        4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h11111111);

        // Reset state
        #12;
        check("reset.rdata", rdata, 32'h0);
        check("reset.pulses", {29'd0, rvalid, wdone, err}, 32'h0);
        check("reset.busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Vector table at LATENCY=2
        last_rdata = 32'h0;
        for (int i = 0; i < NV; i++) begin
            check($sformatf("v%0d.rdata_hold", i), rdata, last_rdata);
            xact(vt[i], lat, nbusy, rv, wd, er, rb, rd_o);
            check($sformatf("v%0d.latency", i), 32'(lat), 32'd2);
            check($sformatf("v%0d.busy_cycles", i), 32'(nbusy), 32'd2);
            check($sformatf("v%0d.resp_busy", i), 32'(rb), 32'd0);
            check($sformatf("v%0d.rvalid", i), 32'(rv), 32'(vt[i].xrv));
            check($sformatf("v%0d.wdone", i), 32'(wd), 32'(vt[i].xwd));
            check($sformatf("v%0d.err", i), 32'(er), 32'(vt[i].xerr));
            if (vt[i].xrv) begin
                check($sformatf("v%0d.rdata", i), rd_o, vt[i].xrdata);
                last_rdata = vt[i].xrdata;
            end
        end

        // Reset during WAIT of a store to 0x20 aborts it
        readWr = 1'b0; writeWr = 1'b1; memAddr = 32'h20; memData = 32'h22222222; wmask = 4'b1111;
        @(posedge clk); #2;
        check("rstmid.wait_busy", 32'(busy), 32'd1);
        writeWr = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid.busy", 32'(busy), 32'd0);
        check("rstmid.pulses", {29'd0, rvalid, wdone, err}, 32'h0);
        check("rstmid.rdata", rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xact(mk(1'b1, 1'b0, 32'h20, 32'h0, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h11111111),
             lat, nbusy, rv, wd, er, rb, rd_o);
        check("rstmid.reload_rdata", rd_o, 32'h11111111);
        check("rstmid.reload_rvalid", 32'(rv), 32'd1);

        // Back-to-back loads, upstream advancing only when busy is low
        ba[0] = 32'h10; bm[0] = 4'b0001; bx[0] = 32'h000000EF;
        ba[1] = 32'h20; bm[1] = 4'b1100; bx[1] = 32'h00001111;
        ba[2] = 32'h10; bm[2] = 4'b1111; bx[2] = 32'hDEABBEEF;
        ba[3] = 32'h20; bm[3] = 4'b0010; bx[3] = 32'h00000011;
        cyc = 0; pulses = 0; last_pulse = -1;
        for (int i = 0; i < 4; i++) begin
            readWr = 1'b1; writeWr = 1'b0; memAddr = ba[i]; rmask = bm[i];
            guard = 0;
            do begin
                @(negedge clk);
                cyc++;
                guard++;
                if (rvalid) begin
                    pulses++;
                    if (pulses <= 4)
                        check($sformatf("b2b%0d.rdata", pulses - 1), rdata, bx[pulses - 1]);
                    if (last_pulse >= 0)
                        check($sformatf("b2b%0d.spacing", pulses - 1), 32'(cyc - last_pulse), 32'd3);
                    last_pulse = cyc;
                end
            end while (busy && guard < 40);
            @(posedge clk); #1;
        end
        readWr = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rvalid) pulses++;
        end
        check("b2b.pulse_count", 32'(pulses), 32'd4);

        // Latency sweep
        @(posedge clk); #1;
        sweep(0, 1);
        @(posedge clk); #1;
        sweep(1, 3);
        @(posedge clk); #1;
        sweep(2, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the far end of the execute stage's memory request interface (address, write data, read/write enables, byte masks).
- Holds a word-organised data RAM with byte-lane writes and a configurable access latency.
- Stalls the pipeline via `busy` until each request completes.
- Returns right-aligned load data with a valid pulse, plus error reporting for illegal requests.

Parameters:
- ADDR_W, 10, word-index bits; RAM depth = 2^ADDR_W 32-bit words.
- LATENCY, 2, cycles from accept edge to response cycle. Legal values 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- memAddr  in  32  byte address; word index = memAddr[ADDR_W+1:2].
- memData  in  32  store data, lane-positioned (byte i on bits 8i+7:8i).
- readWr  in  1  load request.
- writeWr  in  1  store request.
- rmask  in  4  load lane mask.
- wmask  in  4  store lane mask.
- rdata  out  32  load result, selected lanes right-aligned, zero-extended.
- rvalid  out  1  one-cycle pulse: load response valid.
- wdone  out  1  one-cycle pulse: store committed or rejected.
- busy  out  1  pipeline stall request.
- err  out  1  one-cycle pulse alongside rvalid/wdone when the request was rejected.

Behaviour:
- Reset (async, any state): state=IDLE, cnt=0, all outputs 0. RAM contents are not cleared.
- States:
  - IDLE: at a rising edge with `req=readWr|writeWr`, capture addr, data, masks, op and the error status. Go to WAIT with cnt=LATENCY-1, or go directly to RESP if LATENCY==1.
  - WAIT: cnt decrements each edge. At the edge where cnt==1, go to RESP.
  - RESP: asserted for exactly one cycle, then RESP->IDLE unconditionally. The request is never re-accepted at the RESP exit edge, because the upstream still holds the old request at that edge.
- busy:
  - = (state==IDLE & req) | (state==WAIT). Combinational.
  - 0 in RESP, so the pipeline advances at the RESP exit edge.
- Latency: response cycle = LATENCY cycles after the accept edge. Back-to-back requests therefore cost LATENCY+1 cycles each.
- Stores:
  - The RAM lane write happens at the edge entering RESP, only for lanes with wmask[i]=1 and no error.
  - wdone=1 in RESP.
- Loads:
  - The RAM is read using the captured index. Data is registered into rdata at the edge entering RESP; rvalid=1 in RESP.
  - Extraction: mask 0001/0010/0100/1000 gives the byte zero-extended to 32. Mask 0011/1100 gives the halfword zero-extended. Mask 1111 gives the full word.
  - rdata holds its value after RESP until the next load response. It is 0 on error.
- Errors are latched at accept and output as err=1 in RESP. No write is performed. Error conditions:
  - readWr and writeWr both 1. Both rvalid and wdone pulse.
  - Active mask not in {0001,0010,0100,1000,0011,1100,1111}.
  - memAddr[31:ADDR_W+2] is nonzero (out of range).
- Lane selection uses the mask only; memAddr[1:0] is ignored.
- Inputs that change during WAIT are ignored, because the captured copy is used.
- Reset asserted in WAIT/RESP aborts the access. A store whose commit edge coincides with reset assertion does not write.

Decomposition:
- Add to the shared header Helpers.v:
  - state encoding constants DMEM_IDLE/DMEM_WAIT/DMEM_RESP;
  - legal mask constants MASK_B0..MASK_B3, MASK_H0, MASK_H1, MASK_W;
  - a lane-extract function (mask, word -> zero-extended result).
- Sub-module dmem_bank_ram: 2^ADDR_W x 32 synchronous RAM with 4 byte-write enables and a registered read port. No reset on the array.

Test Plan:
- Word store/load, LATENCY=2: store memAddr=0x10, memData=0xDEADBEEF, wmask=1111; then load the same address with rmask=1111. Required: busy high 2 cycles each; wdone then rvalid pulse in the 3rd cycle; rdata=0xDEADBEEF; err=0.
- Byte lanes: store 0x00AB0000 with wmask=0100 over the previous word; load with rmask=0100 -> rdata=0x000000AB. Load with rmask=1100 -> rdata=0x0000DEAB.
- Latency sweep LATENCY=1,3,15: count cycles from accept edge to rvalid; they must equal LATENCY. busy is 0 in the response cycle, and no second accept occurs while inputs are held one extra cycle.
- Illegal requests: each of the following gives err=1 with the response pulse, no RAM change (verified by a following load), and rdata=0 for loads:
  - rmask=0101;
  - readWr=writeWr=1;
  - memAddr=0x0000_1000 with ADDR_W=10.
- Reset mid-op: assert rst in WAIT of a store to 0x20 (prior content 0x11111111). Required: outputs 0 immediately, state IDLE; a later load of 0x20 returns 0x11111111.
- Back-to-back: four consecutive loads with upstream stalling on busy. Required: exactly four rvalid pulses, correct data for each, and spacing of LATENCY+1 cycles.
